// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a small pop FIFO.
// Bytes become visible on rx_valid one cycle after the stop-bit decision; error pulses are one cycle wide.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic [4:0] fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t state;

  logic          rx_s1;
  logic          rxs;
  logic          rxs_prev;
  logic [15:0]   div_cnt;
  logic          tick;
  logic          start_edge;
  logic [3:0]    sub;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_s1    <= rx;
      rxs      <= rx_s1;
      rxs_prev <= rxs;
    end
  end

  assign start_edge = !rxs && rxs_prev;
  assign tick       = (div_cnt == 16'(BAUD_DIV - 1));

  // Divider is re-phased at the start edge so the first half-bit lands mid start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if ((state == IDLE && start_edge) || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign push = (state == STOP) && tick && (sub == 4'd15) && rxs && !par_bad;
`else
  assign push = (state == STOP) && tick && (sub == 4'd15) && rxs;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sub       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) sub <= sub + 4'd1;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            sub   <= '0;
          end
        end
        START: begin
          if (tick && sub == 4'd7) begin
            sub <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick && sub == 4'd15) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              sub <= '0;
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick && sub == 4'd15) begin
            par_bad    <= (rxs != ^shreg);
            parity_err <= (rxs != ^shreg);
            state      <= STOP;
            sub        <= '0;
          end
        end
`endif
        STOP: begin
          if (tick && sub == 4'd15) begin
            sub <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end
        end
        BRK: begin
          if (rxs) begin
            state <= IDLE;
            sub   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop   = rx_ready && (count != 5'd0);
  assign full  = (count == 5'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + 5'(wr_en) - 5'(pop);
    end
  end

  assign rx_valid = (count != 5'd0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_cnt = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a byte-queue reference model.
module tb_uart_rx_fifo;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int BIT   = 16 * BD;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Cycles from the start-bit drive edge to the stop-bit decision edge.
  localparam int DEC_OFS = 2 + BD * (8 + 16 * NB);

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic [4:0] fifo_cnt;

  uart_rx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0, ovr_cnt = 0, pe_cnt = 0;
  int fe_exp = 0, ovr_exp = 0, pe_exp = 0;
  logic [7:0] q [$];

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frame_err === 1'b1)  fe_cnt++;
      if (overrun === 1'b1)    ovr_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop_bit);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else ovr_exp++;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
    model_push(b);
  endtask

  task automatic pop_chk(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, q[0]});
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(q.pop_front());
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_cnt", {27'd0, fifo_cnt}, 32'd0);
    chk("rst_fe", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_pe", {31'd0, parity_err}, 32'd0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    // Two bytes held without popping, then popped in order.
    send_good(8'h55);
    send_good(8'hA3);
    chk("two_cnt", {27'd0, fifo_cnt}, 32'd2);
    chk("two_head", {24'd0, rx_data}, 32'h55);
    pop_chk("pop55");
    chk("after_pop_head", {24'd0, rx_data}, 32'hA3);
    pop_chk("popA3");
    chk("empty_cnt", {27'd0, fifo_cnt}, 32'd0);

    // Randomized bytes with random pops.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_good(b);
      chk("rnd_cnt", {27'd0, fifo_cnt}, q.size());
      if ($urandom_range(1, 0) == 1 && q.size() > 0) pop_chk("rnd_pop");
    end
    while (q.size() > 0) pop_chk("drain1");
    chk("rnd_ovr", ovr_cnt, ovr_exp);

    // Start-bit glitch: low for 3 ticks only.
    @(negedge clk); rx = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_cnt", {27'd0, fifo_cnt}, 32'd0);
    chk("glitch_fe", fe_cnt, fe_exp);
    chk("glitch_ovr", ovr_cnt, ovr_exp);

    // Framing error followed by a long break: one pulse only.
    send_good(8'h9A);
    send_frame(8'h3C, 1'b0, 1'b0);
    fe_exp++;
    repeat (30 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("brk_fe", fe_cnt, fe_exp);
    chk("brk_cnt", {27'd0, fifo_cnt}, 32'd1);
    while (q.size() > 0) pop_chk("drain2");

    // Overrun: one more byte than the FIFO holds.
    for (int i = 0; i < DEPTH + 1; i++) send_good(8'($urandom));
    chk("ovr_cnt_full", {27'd0, fifo_cnt}, DEPTH);
    chk("ovr_pulse", ovr_cnt, ovr_exp);

    // Full FIFO with a pop exactly on the stop-decision cycle.
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (DEC_OFS) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(b);
    chk("fullpop_cnt", {27'd0, fifo_cnt}, DEPTH);
    chk("fullpop_ovr", ovr_cnt, ovr_exp);
    while (q.size() > 0) pop_chk("drain3");

    // Reset in the middle of the data bits of 0xFF.
    send_good(8'h44);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cnt", {27'd0, fifo_cnt}, 32'd0);
    chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    q.delete();
    repeat (7 * BIT) @(negedge clk);
    send_good(8'h12);
    chk("post_rst_cnt", {27'd0, fifo_cnt}, 32'd1);
    pop_chk("post_rst_pop");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    pe_exp++;
    chk("par_bad_cnt", {27'd0, fifo_cnt}, 32'd0);
    send_good(8'h07);
    chk("par_ok_cnt", {27'd0, fifo_cnt}, 32'd1);
    pop_chk("par_ok_pop");
`endif

    repeat (BIT) @(negedge clk);
    chk("final_fe", fe_cnt, fe_exp);
    chk("final_ovr", ovr_cnt, ovr_exp);
    chk("final_pe", pe_cnt, pe_exp);
    chk("final_cnt", {27'd0, fifo_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
